// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: reset vector, NOP encoding,
// fetch FSM encoding and the IF->ID bundle.
package cpu_defs;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_CANCEL = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } if_id_t;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid buffer for a fetched word that
// arrived while ID was stalled.
module if_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic        clr,
  input  logic [31:0] wr_data,
  input  logic [31:0] wr_pc,
  output logic        valid,
  output logic [31:0] data,
  output logic [31:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (wr) begin
      valid <= 1'b1;
      data  <= wr_data;
      pc    <= wr_pc;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: SRAM-like fetch FSM with
// one outstanding request, branch latch and flush.
module if_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  input  logic        if_id_stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_q, pend_d;
  logic [31:0]  tgt_q, tgt_d;
  logic         adel_done_q, adel_done_d;
  if_id_t       id_q, id_d;

  logic         misal;
  logic         advance;
  logic [31:0]  next_pc;
  logic         hb_wr, hb_clr, hb_valid;
  logic [31:0]  hb_data, hb_pc;

  assign misal     = |pc_q[1:0];
  assign inst_req  = !rst && (state_q == S_REQ) && !misal;
  assign inst_addr = pc_q;
  assign id_pc     = id_q.pc;
  assign id_inst   = id_q.inst;
  assign id_adel   = id_q.adel;

  // a branch resolving in the delivery cycle redirects too
  assign next_pc = br_taken ? br_target :
                   pend_q   ? tgt_q     :
                   pc_q + 32'd4;

  if_hold_buf u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr      (hb_wr),
    .clr     (hb_clr),
    .wr_data (inst_rdata),
    .wr_pc   (pc_q),
    .valid   (hb_valid),
    .data    (hb_data),
    .pc      (hb_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    tgt_d       = tgt_q;
    adel_done_d = adel_done_q;
    id_d        = if_id_stall ? id_q : '0;
    hb_wr       = 1'b0;
    hb_clr      = 1'b0;
    advance     = 1'b0;

    if (br_taken) begin
      pend_d = 1'b1;
      tgt_d  = br_target;
    end

    unique case (state_q)
      S_REQ: begin
        if (misal) begin
          if (!if_id_stall && !adel_done_q) begin
            id_d        = '{pc: pc_q, inst: NOP, adel: 1'b1};
            adel_done_d = 1'b1;
          end
        end else if (inst_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (!if_id_stall) begin
            id_d    = '{pc: pc_q, inst: inst_rdata, adel: 1'b0};
            advance = 1'b1;
            state_d = S_REQ;
          end else begin
            hb_wr   = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!if_id_stall && hb_valid) begin
          id_d    = '{pc: hb_pc, inst: hb_data, adel: 1'b0};
          advance = 1'b1;
          hb_clr  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_CANCEL: begin
        if (inst_data_ok) state_d = S_REQ;
      end
    endcase

    if (advance) begin
      pc_d   = next_pc;
      pend_d = 1'b0;
    end

    // flush overrides everything, including a same-cycle branch
    if (flush) begin
      pc_d        = flush_pc;
      pend_d      = 1'b0;
      hb_wr       = 1'b0;
      hb_clr      = 1'b1;
      id_d        = '0;
      adel_done_d = 1'b0;
      unique case (state_q)
        S_REQ:    state_d = (inst_req && inst_addr_ok) ?
                            S_CANCEL : S_REQ;
        S_WAIT:   state_d = inst_data_ok ? S_REQ : S_CANCEL;
        S_HOLD:   state_d = S_REQ;
        S_CANCEL: state_d = inst_data_ok ? S_REQ : S_CANCEL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      tgt_q       <= '0;
      adel_done_q <= 1'b0;
      id_q        <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      tgt_q       <= tgt_d;
      adel_done_q <= adel_done_d;
      id_q        <= id_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: table of fetch transactions plus
// hand-written flush / misaligned / flush+branch sequences.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        inst_data_ok = 1'b0;
  logic        if_id_stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          a_lat;
    int          d_lat;
    int          stall;
    bit          br;
    logic [31:0] pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .if_id_stall  (if_id_stall),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_adel      (id_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2408_0001;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic deliver_chk();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got delivery %h expected none",
               id_pc);
      return;
    end
    e = sb.pop_front();
    chk("id_pc", id_pc, e.pc);
    chk("id_inst", id_inst, e.inst);
    chk("id_adel", {31'd0, id_adel}, 32'd0);
    chk("next_req", {31'd0, inst_req}, 32'd1);
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic fetch_one(vec_t v);
    int  n = 0;
    bit  got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (c == 0) chk("req_first", {31'd0, inst_req}, 32'd1);
      if (inst_req) begin
        if (n == v.a_lat) begin
          chk("req_addr", inst_addr, v.pc);
          sb.push_back('{pc: v.pc, inst: mem(v.pc)});
          inst_addr_ok = 1'b1;
          got = 1;
        end
        n++;
      end
      @(posedge clk);
      #1 inst_addr_ok = 1'b0;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no request expected %h",
               v.pc);
      return;
    end
    for (int k = 0; k < v.d_lat; k++) begin
      @(negedge clk);
      chk("wait_noreq", {31'd0, inst_req}, 32'd0);
      if (k == 0 && v.br) begin
        br_taken  = 1'b1;
        br_target = 32'hBFC0_0100;
      end
      if (k == v.d_lat - 1) begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem(inst_addr);
        if_id_stall  = (v.stall > 0);
      end
      @(posedge clk);
      #1;
      inst_data_ok = 1'b0;
      br_taken     = 1'b0;
    end
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      chk("stall_hold", id_pc, 32'd0);
      chk("hold_noreq", {31'd0, inst_req}, 32'd0);
      if (s == v.stall - 1) if_id_stall = 1'b0;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    deliver_chk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 1, 0, 1'b0, 32'hBFC0_0000};
    vecs[1] = '{0, 1, 3, 1'b0, 32'hBFC0_0004};
    vecs[2] = '{2, 3, 0, 1'b0, 32'hBFC0_0008};
    vecs[3] = '{1, 2, 0, 1'b1, 32'hBFC0_000C};
    vecs[4] = '{0, 1, 0, 1'b0, 32'hBFC0_0100};
    vecs[5] = '{0, 2, 2, 1'b0, 32'hBFC0_0104};
    vecs[6] = '{0, 1, 0, 1'b0, 32'hBFC0_0108};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_inst", id_inst, 32'd0);
    chk("rst_id_adel", {31'd0, id_adel}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) fetch_one(vecs[i]);

    // flush while waiting; stale data_ok two cycles later
    @(negedge clk);
    chk("fl_req_addr", inst_addr, 32'hBFC0_010C);
    inst_addr_ok = 1'b1;
    @(posedge clk);
    #1 inst_addr_ok = 1'b0;
    @(negedge clk);
    flush    = 1'b1;
    flush_pc = 32'hBFC0_0380;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("cancel_id_pc", id_pc, 32'd0);
    chk("cancel_noreq", {31'd0, inst_req}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 inst_data_ok = 1'b0;
    @(negedge clk);
    chk("stale_id_pc", id_pc, 32'd0);
    chk("stale_id_inst", id_inst, 32'd0);
    chk("redir_req", {31'd0, inst_req}, 32'd1);
    chk("redir_addr", inst_addr, 32'hBFC0_0380);
    @(posedge clk);
    #1;
    fetch_one('{0, 1, 0, 1'b0, 32'hBFC0_0380});

    // misaligned flush target
    @(negedge clk);
    flush    = 1'b1;
    flush_pc = 32'hBFC0_0382;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("adel_noreq", {31'd0, inst_req}, 32'd0);
    chk("adel_pre_pc", id_pc, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("adel_flag", {31'd0, id_adel}, 32'd1);
    chk("adel_pc", id_pc, 32'hBFC0_0382);
    chk("adel_inst", id_inst, 32'd0);
    chk("adel_noreq2", {31'd0, inst_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("adel_once", {31'd0, id_adel}, 32'd0);
      chk("adel_park", {31'd0, inst_req}, 32'd0);
    end

    // flush and branch together: flush wins
    flush     = 1'b1;
    flush_pc  = 32'hBFC0_0500;
    br_taken  = 1'b1;
    br_target = 32'hBFC0_0600;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    br_taken = 1'b0;
    @(negedge clk);
    chk("fb_req", {31'd0, inst_req}, 32'd1);
    chk("fb_addr", inst_addr, 32'hBFC0_0500);
    @(posedge clk);
    #1;
    fetch_one('{0, 1, 0, 1'b0, 32'hBFC0_0500});
    fetch_one('{1, 1, 0, 1'b0, 32'hBFC0_0504});

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC0_0000, first fetch address after reset.
REQ-002 SHALL have ports: clk in 1, clock; rst in 1, reset, asynchronous, active-high.
REQ-003 SHALL have: inst_req out 1, SRAM-like request; inst_addr out 32, fetch address; inst_addr_ok in 1, address accepted; inst_rdata in 32; inst_data_ok in 1, data valid.
REQ-004 SHALL have: if_id_stall in 1, hold ID registers; flush in 1, cancel and redirect (exception/eret); flush_pc in 32.
REQ-005 SHALL have: br_taken in 1, branch resolved in ID; br_target in 32.
REQ-006 SHALL have: id_pc out 32 (0 = bubble), id_inst out 32, id_adel out 1 (misaligned-fetch exception).

Function
REQ-007 SHALL keep at most one outstanding request; states REQ, WAIT, HOLD, CANCEL.
REQ-008 REQ: inst_req=1, inst_addr=pc; addr_ok -> WAIT; no addr_ok -> remain, address may change next cycle.
REQ-009 WAIT: inst_req=0; data_ok with !if_id_stall -> load id_pc=pc, id_inst=inst_rdata, pc=next_pc, -> REQ; ID registers update at end of the data_ok cycle, next inst_req in the following cycle.
REQ-010 WAIT: data_ok with if_id_stall -> capture rdata and pc into hold buffer, -> HOLD; no data lost.
REQ-011 HOLD: when !if_id_stall, transfer buffer to ID registers, advance pc, -> REQ.
REQ-012 next_pc SHALL be pc+4 (wrap modulo 2^32), or the latched branch target if one is pending.
REQ-013 br_taken SHALL latch br_target as pending; the in-flight/held fetch (delay slot) SHALL NOT be cancelled; pending cleared on use.
REQ-014 flush SHALL set pc=flush_pc, clear pending branch, clear hold buffer, and zero id_pc/id_inst/id_adel regardless of if_id_stall.
REQ-015 flush in WAIT without data_ok, or in REQ with addr_ok the same cycle -> CANCEL; CANCEL discards the next data_ok, then -> REQ.
REQ-016 flush in WAIT with data_ok the same cycle -> data discarded, -> REQ.
REQ-017 flush in REQ without addr_ok -> stay REQ; inst_addr=flush_pc next cycle.
REQ-018 flush and br_taken in the same cycle: flush wins, branch dropped.
REQ-019 pc[1:0]!=0 in REQ: no inst_req; when ID not stalled, deliver id_pc=pc, id_inst=0, id_adel=1; then wait in REQ until flush.
REQ-020 When if_id_stall and no delivery, ID outputs SHALL hold value.

Reset
REQ-021 During rst: state=REQ, pc=RESET_PC, inst_req=0, id_pc=0, id_inst=0, id_adel=0, pending and hold cleared.
REQ-022 inst_req SHALL rise in the first cycle after rst deasserts; rst mid-transaction abandons it with no discard tracking.

Structure
REQ-023 RESET_PC default, NOP value, and state encoding SHALL live in the shared cpu_defs package.
REQ-024 The one-entry hold buffer (data, pc, valid) SHALL be sub-module if_hold_buf; the FSM stays in if_fetch.

Verification
REQ-025 Reset release, addr_ok and data_ok each 1 cycle later, rdata=32'h2408_0001 -> inst_addr=BFC0_0000, then id_pc=BFC0_0000, id_inst=24080001, next inst_addr=BFC0_0004.
REQ-026 data_ok while if_id_stall high for 3 cycles -> ID holds previous; after stall drops, id_inst=captured word, next request at pc+4.
REQ-027 br_taken br_target=BFC0_0100 while delay-slot fetch in WAIT -> delay slot delivered, next inst_addr=BFC0_0100.
REQ-028 flush flush_pc=BFC0_0380 in WAIT, stale data_ok 2 cycles later -> stale word dropped, id_pc=0, next inst_addr=BFC0_0380.
REQ-029 flush_pc=BFC0_0382 -> no inst_req, id_adel=1, id_pc=BFC0_0382, id_inst=0.
REQ-030 Simultaneous flush and br_taken -> fetch at flush_pc, branch target never issued.
